// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: access encodings, FSM states
// and the access-size decode helper.
package mem_arbiter_pkg;

  localparam int RegLen    = 32;
  localparam int Funct3Len = 3;

  localparam logic Read    = 1'b0;
  localparam logic Write   = 1'b1;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [RegLen-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [Funct3Len-1:0] LB  = 3'b000;
  localparam logic [Funct3Len-1:0] LH  = 3'b001;
  localparam logic [Funct3Len-1:0] LW  = 3'b010;
  localparam logic [Funct3Len-1:0] LBU = 3'b100;
  localparam logic [Funct3Len-1:0] LHU = 3'b101;
  localparam logic [Funct3Len-1:0] SB  = 3'b000;
  localparam logic [Funct3Len-1:0] SH  = 3'b001;
  localparam logic [Funct3Len-1:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the last byte of an access; the unused size code 11 falls back to a word
  function automatic logic [1:0] size_last(input logic [Funct3Len-1:0] f3);
    logic [1:0] last;
    case (f3)
      LB, LBU: last = 2'd0;
      LH, LHU: last = 2'd1;
      default: last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// mem_byte_seq: byte counter, base+k address generator, store-byte selector
// and little-endian load assembler for one byte-serial RAM access.
module mem_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [1:0]        i_len,
  input  logic [31:0]       i_store,
  input  logic              i_step,
  input  logic              i_capture,
  input  logic [7:0]        i_din,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_dout,
  output logic [2:0]        o_cnt,
  output logic [1:0]        o_len,
  output logic [31:0]       o_data
);

  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_len;
  logic [31:0]       r_store;
  logic [2:0]        r_cnt;
  logic [31:0]       r_data;
  logic [1:0]        w_off;

  // Offset saturates at the last byte so the trailing capture cycle and idle keep base+N-1
  assign w_off  = (r_cnt > {1'b0, r_len}) ? r_len : r_cnt[1:0];
  assign o_addr = r_base + ADDR_W'(w_off);
  assign o_cnt  = r_cnt;
  assign o_len  = r_len;
  assign o_data = r_data;

  always_comb begin
    o_dout = 8'h00;
    case (w_off)
      2'd0:    o_dout = r_store[7:0];
      2'd1:    o_dout = r_store[15:8];
      2'd2:    o_dout = r_store[23:16];
      2'd3:    o_dout = r_store[31:24];
      default: o_dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_base  <= '0;
      r_len   <= 2'd0;
      r_store <= ZERO_WORD;
      r_cnt   <= 3'd0;
      r_data  <= ZERO_WORD;
    end else if (i_load) begin
      r_base  <= i_base;
      r_len   <= i_len;
      r_store <= i_store;
      r_cnt   <= 3'd0;
      r_data  <= ZERO_WORD;
    end else begin
      if (i_step) begin
        r_cnt <= r_cnt + 3'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      // The byte on i_din belongs to the address issued one count earlier
      if (i_capture) begin
        case (r_cnt)
          3'd1:    r_data[7:0]   <= i_din;
          3'd2:    r_data[15:8]  <= i_din;
          3'd3:    r_data[23:16] <= i_din;
          3'd4:    r_data[31:24] <= i_din;
          default: r_data        <= r_data;
        endcase
      end else begin
        r_data <= r_data;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM.
// Optional macro MEM_ARB_RDY_EN adds rdy_in, which freezes the block while low.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
`ifdef MEM_ARB_RDY_EN
  input  logic              rdy_in,
`endif
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [31:0]       if_inst_o,
  input  logic              wr_enable_i,
  input  logic              wr_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       store_data_i,
  output logic              is_mem_output_o,
  output logic              load_store_ready_o,
  output logic [31:0]       load_data_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o
);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_mem;
  logic              r_wr;
  logic              r_is_mem;
  logic              w_run;
  logic              w_req;
  logic              w_grant;
  logic              w_step;
  logic              w_capture;
  logic              w_last_cycle;
  logic [ADDR_W-1:0] w_base;
  logic [1:0]        w_len_in;
  logic [31:0]       w_store;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_dout;
  logic [2:0]        w_cnt;
  logic [1:0]        w_len;
  logic [31:0]       w_data;

`ifdef MEM_ARB_RDY_EN
  assign w_run = rdy_in;
`else
  assign w_run = Enable;
`endif

  // MEM wins over IF; the winner's request is latched into the sequencer
  assign w_req     = wr_enable_i | if_req_i;
  assign w_grant   = (r_state == IDLE) & w_run & w_req;
  assign w_base    = wr_enable_i ? ls_addr_i : if_addr_i;
  assign w_len_in  = wr_enable_i ? size_last(funct3_i) : 2'd3;
  assign w_store   = wr_enable_i ? store_data_i : ZERO_WORD;
  assign w_step    = (r_state == BUSY) & w_run;
  assign w_capture = w_step & (r_wr == Read) & (w_cnt >= 3'(RAM_LAT));

  // Reads need RAM_LAT trailing capture cycles after the last address
  assign w_last_cycle = (r_wr == Write) ? (w_cnt == {1'b0, w_len})
                                        : (w_cnt == ({1'b0, w_len} + 3'(RAM_LAT)));

  mem_byte_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_load    (w_grant),
    .i_base    (w_base),
    .i_len     (w_len_in),
    .i_store   (w_store),
    .i_step    (w_step),
    .i_capture (w_capture),
    .i_din     (mem_din_i),
    .o_addr    (w_addr),
    .o_dout    (w_dout),
    .o_cnt     (w_cnt),
    .o_len     (w_len),
    .o_data    (w_data)
  );

  assign mem_a_o         = w_addr;
  assign is_mem_output_o = r_is_mem;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else if (w_run) begin
      r_state <= w_next;
    end else begin
      r_state <= r_state;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (w_last_cycle) begin
          w_next = DONE;
        end else begin
          w_next = BUSY;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_owner_mem <= Disable;
      r_wr        <= Read;
      r_is_mem    <= Disable;
    end else if (w_grant) begin
      r_owner_mem <= wr_enable_i;
      r_wr        <= wr_enable_i ? wr_i : Read;
      r_is_mem    <= wr_enable_i;
    end else if (w_run && (r_state == DONE)) begin
      r_is_mem    <= Disable;
    end else begin
      r_is_mem    <= r_is_mem;
    end
  end

  always_comb begin
    if_ready_o         = Disable;
    if_inst_o          = ZERO_WORD;
    load_store_ready_o = Disable;
    load_data_o        = ZERO_WORD;
    mem_wr_o           = Disable;
    mem_dout_o         = 8'h00;
    case (r_state)
      BUSY: begin
        if (r_wr == Write) begin
          mem_wr_o   = w_run;
          mem_dout_o = w_dout;
        end else begin
          mem_wr_o   = Disable;
          mem_dout_o = 8'h00;
        end
      end
      DONE: begin
        if (r_owner_mem) begin
          load_store_ready_o = Enable;
          load_data_o        = (r_wr == Write) ? ZERO_WORD : w_data;
        end else begin
          if_ready_o = Enable;
          if_inst_o  = w_data;
        end
      end
      default: begin
        mem_wr_o = Disable;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected ready pulses and RAM writes are
// queued at issue time and checked as the DUT produces them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_inst_o;
  logic        wr_enable_i;
  logic        wr_i;
  logic [2:0]  funct3_i;
  logic [31:0] ls_addr_i;
  logic [31:0] store_data_i;
  logic        is_mem_output_o;
  logic        load_store_ready_o;
  logic [31:0] load_data_o;
  logic [7:0]  mem_din_i;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
`ifdef MEM_ARB_RDY_EN
  logic        rdy_in;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
`ifdef MEM_ARB_RDY_EN
    .rdy_in             (rdy_in),
`endif
    .if_req_i           (if_req_i),
    .if_addr_i          (if_addr_i),
    .if_ready_o         (if_ready_o),
    .if_inst_o          (if_inst_o),
    .wr_enable_i        (wr_enable_i),
    .wr_i               (wr_i),
    .funct3_i           (funct3_i),
    .ls_addr_i          (ls_addr_i),
    .store_data_i       (store_data_i),
    .is_mem_output_o    (is_mem_output_o),
    .load_store_ready_o (load_store_ready_o),
    .load_data_o        (load_data_o),
    .mem_din_i          (mem_din_i),
    .mem_dout_o         (mem_dout_o),
    .mem_a_o            (mem_a_o),
    .mem_wr_o           (mem_wr_o)
  );

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [39:0] wq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  logic [7:0]  ram [0:1023];
  bit   [1023:0] wv;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input logic [9:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return wv[a[9:0]] ? ram[a[9:0]] : pat(a[9:0]);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = mbyte(a + 32'(k));
    return w;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // RAM model with one cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_o === 1'b1) begin
      ram[mem_a_o[9:0]] <= mem_dout_o;
      wv[mem_a_o[9:0]]  <= 1'b1;
    end
    mem_din_i <= mbyte(mem_a_o);
  end

  always @(negedge clk) begin
    exp_t e;
    if ((if_ready_o === 1'b1) || (load_store_ready_o === 1'b1)) begin
      check_eq("ready_overlap", 64'(if_ready_o & load_store_ready_o), 64'd0);
      check_eq("ready_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("ready_owner", 64'(load_store_ready_o), 64'(e.is_mem));
        check_eq("ready_data", 64'(load_store_ready_o ? load_data_o : if_inst_o), 64'(e.data));
        check_eq("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mem_wr_o === 1'b1) begin
      check_eq("write_expected", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) check_eq("ram_write", 64'({mem_a_o, mem_dout_o}), 64'(wq.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_if_ready"}, 64'(if_ready_o), 64'd0);
    check_eq({tag, "_ls_ready"}, 64'(load_store_ready_o), 64'd0);
    check_eq({tag, "_is_mem"}, 64'(is_mem_output_o), 64'd0);
    check_eq({tag, "_mem_wr"}, 64'(mem_wr_o), 64'd0);
    check_eq({tag, "_mem_a"}, 64'(mem_a_o), 64'd0);
    check_eq({tag, "_mem_dout"}, 64'(mem_dout_o), 64'd0);
    check_eq({tag, "_if_inst"}, 64'(if_inst_o), 64'd0);
    check_eq({tag, "_load_data"}, 64'(load_data_o), 64'd0);
  endtask

  // Issue a MEM request in the current (idle) cycle; returns at G+1, or at the next idle cycle
  task automatic mem_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_load,
                         input int extra, input bit wait_done);
    int   g;
    int   n;
    exp_t e;
    g = cyc;
    n = nbytes(f3);
    wr_enable_i  = 1'b1;
    wr_i         = wr;
    funct3_i     = f3;
    ls_addr_i    = a;
    store_data_i = d;
    e.is_mem = 1'b1;
    e.data   = wr ? 32'h0 : exp_load;
    e.cyc    = g + n + (wr ? 1 : 2) + extra;
    sb.push_back(e);
    if (wr) begin
      for (int k = 0; k < n; k++) wq.push_back({a + 32'(k), 8'(d >> (8*k))});
    end
    tick(1);
    wr_enable_i = 1'b0;
    if (wait_done) tick(n + (wr ? 1 : 2) + extra);
  endtask

  task automatic if_push(input logic [31:0] exp_inst, input int rdy_cyc);
    exp_t e;
    e.is_mem = 1'b0;
    e.data   = exp_inst;
    e.cyc    = rdy_cyc;
    sb.push_back(e);
  endtask

  initial begin
    int g;
    rst_in       = 1'b1;
    if_req_i     = 1'b0;
    if_addr_i    = 32'h0;
    wr_enable_i  = 1'b0;
    wr_i         = 1'b0;
    funct3_i     = 3'b000;
    ls_addr_i    = 32'h0;
    store_data_i = 32'h0;
`ifdef MEM_ARB_RDY_EN
    rdy_in       = 1'b1;
`endif
    tick(3);
    check_all_zero("reset");
    rst_in = 1'b0;
    tick(1);

    // SW to 0x100 while IF asks for 0x104 mid-transaction: no preemption
    g = cyc;
    mem_req(1'b1, 3'b010, 32'h100, 32'h44332211, 32'h0, 0, 1'b0);
    tick(1);
    if_req_i  = 1'b1;
    if_addr_i = 32'h104;
    if_push(model_word(32'h104, 4), g + 12);
    tick(4);
    check_eq("addr_hold_idle", 64'(mem_a_o), 64'h103);
    check_eq("idle_no_wr", 64'(mem_wr_o), 64'd0);
    tick(1);
    check_eq("if_first_addr", 64'(mem_a_o), 64'h104);
    if_req_i = 1'b0;
    tick(6);

    // LW at 0x100 with is_mem_output_o window
    check_eq("is_mem_pre", 64'(is_mem_output_o), 64'd0);
    mem_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      check_eq("is_mem_window", 64'(is_mem_output_o), 64'(i <= 6));
      tick(1);
    end

    // SH 0xBEEF to 0x20 (upper store bytes ignored), then read back
    mem_req(1'b1, 3'b001, 32'h20, 32'h1234BEEF, 32'h0, 0, 1'b1);
    mem_req(1'b0, 3'b101, 32'h20, 32'h0, 32'h0000BEEF, 0, 1'b1);

    // IF and LB together: LB first, IF granted at G+4
    g = cyc;
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    mem_req(1'b0, 3'b000, 32'h300, 32'h0, model_word(32'h300, 1), 0, 1'b0);
    if_push(32'h44332211, g + 10);
    tick(4);
    if_req_i = 1'b0;
    tick(6);

    // Size and address corner cases
    mem_req(1'b0, 3'b001, 32'h101, 32'h0, 32'h00003322, 0, 1'b1);
    mem_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h44332211, 0, 1'b1);
    mem_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, model_word(32'hFFFF_FFFE, 4), 0, 1'b1);
    mem_req(1'b1, 3'b000, 32'h3FF, 32'hFFFFFF7E, 32'h0, 0, 1'b1);
    mem_req(1'b0, 3'b100, 32'h3FF, 32'h0, 32'h0000007E, 0, 1'b1);

    // Reset at BUSY k=1 of a fetch abandons it
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    tick(1);
    if_req_i = 1'b0;
    tick(1);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    check_all_zero("midreset");
    tick(10);
    g = cyc;
    if_req_i = 1'b1;
    if_push(32'h44332211, g + 6);
    tick(1);
    if_req_i = 1'b0;
    tick(6);

`ifdef MEM_ARB_RDY_EN
    // Freeze for 3 cycles mid-LW delays ready by exactly 3
    mem_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 3, 1'b0);
    tick(1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("frozen_no_wr", 64'(mem_wr_o), 64'd0);
      check_eq("frozen_addr", 64'(mem_a_o), 64'h101);
      tick(1);
    end
    rdy_in = 1'b1;
    tick(6);
`endif

    tick(5);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("wq_drained", 64'(wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
